// File: rtl/aer_col_sync_rr_pkg.sv
// aer_pkg: shared types and width helper for the clocked AER column interface
package aer_pkg;
  typedef enum logic [1:0] {IDLE, REQ, CLR, WAIT} state_t;
  typedef enum logic {POL_ON, POL_OFF} pol_t;
  function automatic int aw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/aer_col_sync_rr_if.sv
// aer_col_sync_rr_if: column-request / receiver handshake bundle
interface aer_col_sync_rr_if import aer_pkg::*; #(parameter int NCOL = 16);
  localparam int AW = aw_f(NCOL);
  logic [NCOL-1:0] n_cox_on;
  logic [NCOL-1:0] n_cox_off;
  logic            ack;
  logic            greedy;
  logic            aer_dis;
  logic            reqon;
  logic            reqoff;
  logic [AW-1:0]   addrx;
  logic [NCOL-1:0] cix_on;
  logic [NCOL-1:0] cix_off;
  logic            busy;
  modport master (output n_cox_on, n_cox_off, ack, greedy, aer_dis,
                  input  reqon, reqoff, addrx, cix_on, cix_off, busy);
  modport slave  (input  n_cox_on, n_cox_off, ack, greedy, aer_dis,
                  output reqon, reqoff, addrx, cix_on, cix_off, busy);
endinterface

// File: rtl/aer_col_sync_rr_arb.sv
// rr_arb_n: combinational rotate-priority picker, first pending index at or after start
module rr_arb_n import aer_pkg::*; #(
  parameter  int NCOL = 16,
  localparam int AW   = aw_f(NCOL)
) (
  input  logic [NCOL-1:0] pend,
  input  logic [AW-1:0]   start,
  output logic            valid,
  output logic [AW-1:0]   grant
);
  always_comb begin
    valid = |pend;
    grant = '0;
    for (int k = NCOL - 1; k >= 0; k--) begin
      if (pend[(int'(start) + k) % NCOL]) grant = AW'((int'(start) + k) % NCOL);
    end
  end
endmodule

// File: rtl/aer_col_sync_rr.sv
// aer_col_sync_rr: synchronised round-robin AER column arbiter with 4-phase handshake and timed column reset
module aer_col_sync_rr import aer_pkg::*; #(
  parameter  int NCOL        = 16,
  parameter  int RST_HOLD    = 2,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = aw_f(NCOL)
) (
  input logic clk,
  input logic rst,
  aer_col_sync_rr_if.slave bus
);
  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  logic [SYNC_STAGES-1:0][NCOL-1:0] on_q, on_d, off_q, off_d;
  logic [SYNC_STAGES-1:0]           ack_q, ack_d;
  logic [NCOL-1:0] on_s, off_s, pend, hit;
  logic            ack_s, valid, rel;
  logic [AW-1:0]   grant, start, ptr_inc;
  state_t          state_q, state_d;
  pol_t            pol_q, pol_d;
  logic [AW-1:0]   ptr_q, ptr_d, addr_q, addr_d;
  logic            pair_q, pair_d, reqon_q, reqon_d, reqoff_q, reqoff_d;
  logic [NCOL-1:0] cix_on_q, cix_on_d, cix_off_q, cix_off_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  assign on_d  = {on_q[SYNC_STAGES-2:0], bus.n_cox_on};
  assign off_d = {off_q[SYNC_STAGES-2:0], bus.n_cox_off};
  assign ack_d = {ack_q[SYNC_STAGES-2:0], bus.ack};
  assign on_s  = on_q[SYNC_STAGES-1];
  assign off_s = off_q[SYNC_STAGES-1];
  assign ack_s = ack_q[SYNC_STAGES-1];
  assign pend  = ~on_s | ~off_s;
  assign hit   = NCOL'(1) << addr_q;
  assign rel   = (pol_q == POL_ON) ? on_s[addr_q] : off_s[addr_q];
  assign ptr_inc = (ptr_q == AW'(NCOL - 1)) ? '0 : ptr_q + 1'b1;
  // After an ON grant with OFF also pending, the same column is searched first so OFF follows immediately
  assign start = (bus.greedy || (pair_q && !off_s[ptr_q])) ? ptr_q : ptr_inc;
  rr_arb_n #(.NCOL(NCOL)) u_arb (.pend(pend), .start(start), .valid(valid), .grant(grant));
  always_comb begin
    state_d   = state_q;
    pol_d     = pol_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    pair_d    = pair_q;
    reqon_d   = reqon_q;
    reqoff_d  = reqoff_q;
    cix_on_d  = cix_on_q;
    cix_off_d = cix_off_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: if (!bus.aer_dis && valid && !ack_s) begin
        addr_d   = grant;
        ptr_d    = grant;
        pol_d    = on_s[grant] ? POL_OFF : POL_ON;
        reqon_d  = !on_s[grant];
        reqoff_d = on_s[grant];
        pair_d   = !on_s[grant] && !off_s[grant];
        state_d  = REQ;
      end
      REQ: if (ack_s) begin
        reqon_d   = 1'b0;
        reqoff_d  = 1'b0;
        cix_on_d  = (pol_q == POL_ON) ? hit : '0;
        cix_off_d = (pol_q == POL_OFF) ? hit : '0;
        cnt_d     = '0;
        state_d   = CLR;
      end
      CLR: if (cnt_q == CW'(RST_HOLD - 1)) begin
        cix_on_d  = '0;
        cix_off_d = '0;
        state_d   = WAIT;
      end else cnt_d = cnt_q + 1'b1;
      WAIT: if (!ack_s && rel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_q      <= '1;
      off_q     <= '1;
      ack_q     <= '0;
      state_q   <= IDLE;
      pol_q     <= POL_ON;
      ptr_q     <= AW'(NCOL - 1);
      addr_q    <= '0;
      pair_q    <= 1'b0;
      reqon_q   <= 1'b0;
      reqoff_q  <= 1'b0;
      cix_on_q  <= '0;
      cix_off_q <= '0;
      cnt_q     <= '0;
    end else begin
      on_q      <= on_d;
      off_q     <= off_d;
      ack_q     <= ack_d;
      state_q   <= state_d;
      pol_q     <= pol_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      pair_q    <= pair_d;
      reqon_q   <= reqon_d;
      reqoff_q  <= reqoff_d;
      cix_on_q  <= cix_on_d;
      cix_off_q <= cix_off_d;
      cnt_q     <= cnt_d;
    end
  end
  assign bus.reqon   = reqon_q;
  assign bus.reqoff  = reqoff_q;
  assign bus.addrx   = addr_q;
  assign bus.cix_on  = cix_on_q;
  assign bus.cix_off = cix_off_q;
  assign bus.busy    = state_q != IDLE;
endmodule
